seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath.sv | 195 +++++++++++++++++++
 tb/tb_seq_datapath.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// Register-file datapath: ALU ops on two registers (or reg + immediate), result written back.
// Latency: accept edge to retire edge is 1 cycle, or WIDTH cycles for shift-add MUL.
// Backpressure: in_ready is high only in IDLE; requests seen while busy are dropped, never queued.
module seq_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic [AW-1:0]    addr3,
    input  logic             wr,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [NREGS];

    logic [2:0]       op_q;
    logic [AW-1:0]    dst_q;
    logic             wr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Multiplier: {mul_hi, mul_lo} shifts right one bit per cycle; mul_lo starts as operand B.
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [CW-1:0]    mul_cnt;
    logic [WIDTH:0]   mul_sum;
    logic             mul_last;

    logic             accept;
    logic             retire;
    logic [WIDTH-1:0] b_sel;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;

    logic [WIDTH-1:0] ret_res;
    logic             ret_c;
    logic             ret_v;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign mul_last = (mul_cnt == CNT_LAST);
    assign retire   = (state == EXEC) || ((state == MUL) && mul_last);
    assign b_sel    = use_imm ? imm : regs[addr2];
    assign dbg_data = regs[dbg_addr];

    assign mul_sum  = {1'b0, mul_hi} + {1'b0, (mul_lo[0] ? a_q : {WIDTH{1'b0}})};
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_res  = a_q - b_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: MUL opcode takes the long path, everything else a single EXEC cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (alu_control == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC:    state_nxt = IDLE;
            MUL:     state_nxt = mul_last ? IDLE : MUL;
            default: state_nxt = IDLE;
        endcase
    end

    // Result and flags presented on the retiring edge; MUL uses the final shift-add step
    always_comb begin
        ret_res = '0;
        ret_c   = 1'b0;
        ret_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                ret_res = add_full[WIDTH-1:0];
                ret_c   = add_full[WIDTH];
                ret_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ret_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                ret_res = sub_res;
                ret_c   = (a_q < b_q);
                ret_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: ret_res = a_q & b_q;
            OP_OR:  ret_res = a_q | b_q;
            OP_XOR: ret_res = a_q ^ b_q;
            OP_SLT: ret_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL: ret_res = a_q << b_q[SW-1:0];
            OP_MUL: begin
                ret_res = {mul_sum[0], mul_lo[WIDTH-1:1]};
                ret_c   = |mul_sum[WIDTH:1];
                ret_v   = |mul_sum[WIDTH:1];
            end
            default: ret_res = '0;
        endcase
    end

    // Operand capture on accept; one multiplier bit consumed per MUL cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            dst_q   <= '0;
            wr_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mul_hi  <= '0;
            mul_lo  <= '0;
            mul_cnt <= '0;
        end else if (accept) begin
            op_q    <= alu_control;
            dst_q   <= addr3;
            wr_q    <= wr;
            a_q     <= regs[addr1];
            b_q     <= b_sel;
            mul_hi  <= '0;
            mul_lo  <= b_sel;
            mul_cnt <= '0;
        end else if (state == MUL) begin
            mul_hi  <= mul_sum[WIDTH:1];
            mul_lo  <= {mul_sum[0], mul_lo[WIDTH-1:1]};
            mul_cnt <= mul_cnt + 1'b1;
        end
    end

    // Retirement: outputs, flags, done pulse and write-back (register 0 is never written)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            alu_result <= '0;
            overflow   <= 1'b0;
            carry      <= 1'b0;
            zero       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= retire;
            if (retire) begin
                alu_result <= ret_res;
                overflow   <= ret_v;
                carry      <= ret_c;
                zero       <= (ret_res == '0);
                if (wr_q && (dst_q != '0)) begin
                    regs[dst_q] <= ret_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath (WIDTH=32, NREGS=8).
// Each task drives one scenario and compares against hand-computed values.
// Summary line reports total comparisons and failures.
module tb_seq_datapath;

    localparam int WIDTH = 32;
    localparam int NREGS = 8;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SLT = 3'b101;
    localparam logic [2:0] SLL = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [2:0]  addr1, addr2, addr3;
    logic        wr;
    logic        use_imm;
    logic [31:0] imm;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        done;
    logic [31:0] alu_result;
    logic        overflow, carry, zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .addr1       (addr1),
        .addr2       (addr2),
        .addr3       (addr3),
        .wr          (wr),
        .use_imm     (use_imm),
        .imm         (imm),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .done        (done),
        .alu_result  (alu_result),
        .overflow    (overflow),
        .carry       (carry),
        .zero        (zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op (called #1 after an edge, DUT idle). Optionally keep in_valid high for
    // 'hold' cycles after accept with a decoy write to r6. Returns cycles from accept to done
    // and the number of sampled cycles where in_ready was low.
    task automatic issue(input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] a3, input logic w, input logic ui,
                         input logic [31:0] im, input int hold,
                         output int lat, output int nrdy);
        alu_control = op; addr1 = a1; addr2 = a2; addr3 = a3;
        wr = w; use_imm = ui; imm = im; in_valid = 1'b1;
        @(posedge clk); #1;
        if (hold == 0) begin
            in_valid = 1'b0;
        end else begin
            alu_control = ADD; addr1 = 3'd0; addr3 = 3'd6; use_imm = 1'b1; imm = 32'h55; wr = 1'b1;
        end
        lat = 0;
        nrdy = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (in_ready === 1'b0) nrdy++;
            @(posedge clk); #1;
            lat++;
            if (lat == hold) in_valid = 1'b0;
        end
    endtask

    task automatic load(input logic [2:0] r, input logic [31:0] v);
        int l, n;
        issue(ADD, 3'd0, 3'd0, r, 1'b1, 1'b1, v, 0, l, n);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid = 1'b0; alu_control = '0; addr1 = '0; addr2 = '0; addr3 = '0;
        wr = 1'b0; use_imm = 1'b0; imm = '0; dbg_addr = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", alu_result); end
        checks++; if ({overflow, carry, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {overflow, carry, zero}); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_reg5 got %h want 0", dbg_data); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_imm;
        int l, n;
        issue(ADD, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 32'd5, 0, l, n);
        dbg_addr = 3'd1; #1;
        checks++; if (l !== 1) begin errors++; $display("FAIL add_imm_latency got %0d want 1", l); end
        checks++; if (alu_result !== 32'd5) begin errors++; $display("FAIL add_imm_result got %h want 5", alu_result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_imm_zero got %b want 0", zero); end
        checks++; if (dbg_data !== 32'd5) begin errors++; $display("FAIL add_imm_r1 got %h want 5", dbg_data); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
        checks++; if (alu_result !== 32'd5) begin errors++; $display("FAIL result_hold got %h want 5", alu_result); end
    endtask

    task automatic test_add_sub;
        int l, n;
        load(3'd1, 32'h7FFF_FFFF);
        load(3'd2, 32'h1);
        issue(ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 32'h0, 0, l, n);
        dbg_addr = 3'd3; #1;
        checks++; if (alu_result !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_result got %h want 80000000", alu_result); end
        checks++; if ({overflow, carry} !== 2'b10) begin errors++; $display("FAIL add_ovf_flags got %b want 10", {overflow, carry}); end
        checks++; if (dbg_data !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_r3 got %h want 80000000", dbg_data); end
        issue(SUB, 3'd0, 3'd2, 3'd4, 1'b1, 1'b0, 32'h0, 0, l, n);
        checks++; if (alu_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow_result got %h want ffffffff", alu_result); end
        checks++; if ({overflow, carry} !== 2'b01) begin errors++; $display("FAIL sub_borrow_flags got %b want 01", {overflow, carry}); end
        issue(ADD, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 32'h1, 0, l, n);
        checks++; if ({alu_result, overflow, carry, zero} !== {32'h0, 3'b011}) begin errors++; $display("FAIL add_carry got %h/%b want 0/011", alu_result, {overflow, carry, zero}); end
        issue(SUB, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 32'h1, 0, l, n);
        checks++; if ({alu_result, overflow, carry, zero} !== {32'h0, 3'b001}) begin errors++; $display("FAIL sub_equal got %h/%b want 0/001", alu_result, {overflow, carry, zero}); end
    endtask

    // r1=7FFFFFFF r2=1 r3=80000000 r4=FFFFFFFF at entry
    task automatic test_logic;
        int l, n;
        issue(AND, 3'd1, 3'd0, 3'd5, 1'b1, 1'b1, 32'hF0F0_F0F0, 0, l, n);
        checks++; if (alu_result !== 32'h70F0_F0F0) begin errors++; $display("FAIL and got %h want 70f0f0f0", alu_result); end
        issue(OR, 3'd0, 3'd0, 3'd5, 1'b0, 1'b1, 32'h0, 0, l, n);
        checks++; if ({alu_result, zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL or_zero got %h/%b want 0/1", alu_result, zero); end
        issue(XOR, 3'd1, 3'd0, 3'd5, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, l, n);
        checks++; if ({alu_result, overflow, carry} !== {32'h8000_0000, 2'b00}) begin errors++; $display("FAIL xor got %h/%b want 80000000/00", alu_result, {overflow, carry}); end
        issue(SLT, 3'd4, 3'd2, 3'd5, 1'b0, 1'b0, 32'h0, 0, l, n);
        checks++; if (alu_result !== 32'h1) begin errors++; $display("FAIL slt_neg got %h want 1", alu_result); end
        issue(SLT, 3'd2, 3'd4, 3'd5, 1'b0, 1'b0, 32'h0, 0, l, n);
        checks++; if ({alu_result, zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL slt_pos got %h/%b want 0/1", alu_result, zero); end
        issue(SLL, 3'd2, 3'd0, 3'd5, 1'b0, 1'b1, 32'd33, 0, l, n);
        checks++; if (alu_result !== 32'h2) begin errors++; $display("FAIL sll_wrap got %h want 2", alu_result); end
        issue(SLL, 3'd2, 3'd0, 3'd5, 1'b1, 1'b1, 32'd31, 0, l, n);
        dbg_addr = 3'd5; #1;
        checks++; if (dbg_data !== 32'h8000_0000) begin errors++; $display("FAIL sll31_r5 got %h want 80000000", dbg_data); end
    endtask

    task automatic test_mul;
        int l, n;
        load(3'd1, 32'h0001_0000);
        load(3'd2, 32'h0001_0000);
        issue(MUL, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 32'h0, 5, l, n);
        checks++; if (l !== 32) begin errors++; $display("FAIL mul_latency got %0d want 32", l); end
        checks++; if (n !== 32) begin errors++; $display("FAIL mul_not_ready got %0d want 32", n); end
        checks++; if ({alu_result, overflow, carry, zero} !== {32'h0, 3'b111}) begin errors++; $display("FAIL mul_big got %h/%b want 0/111", alu_result, {overflow, carry, zero}); end
        dbg_addr = 3'd6; #1;
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL mul_ignored_req_r6 got %h want 0", dbg_data); end
        issue(MUL, 3'd1, 3'd0, 3'd6, 1'b1, 1'b1, 32'd3, 0, l, n);
        #1;
        checks++; if ({dbg_data, overflow, carry, zero} !== {32'h0003_0000, 3'b000}) begin errors++; $display("FAIL mul_small got %h/%b want 30000/000", dbg_data, {overflow, carry, zero}); end
        issue(MUL, 3'd4, 3'd0, 3'd7, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, l, n);
        checks++; if ({alu_result, overflow, carry, zero} !== {32'h1, 3'b110}) begin errors++; $display("FAIL mul_max got %h/%b want 1/110", alu_result, {overflow, carry, zero}); end
    endtask

    task automatic test_r0;
        int l, n;
        issue(ADD, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'd9, 0, l, n);
        dbg_addr = 3'd0; #1;
        checks++; if (l !== 1) begin errors++; $display("FAIL r0_done got latency %0d want 1", l); end
        checks++; if (alu_result !== 32'd9) begin errors++; $display("FAIL r0_result got %h want 9", alu_result); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL r0_stays_zero got %h want 0", dbg_data); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops_a1 [3] = '{3'd0, 3'd1, 3'd2};
        logic [2:0]  ops_a2 [3] = '{3'd0, 3'd0, 3'd1};
        logic [2:0]  ops_a3 [3] = '{3'd1, 3'd2, 3'd3};
        logic        ops_ui [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] ops_im [3] = '{32'd10, 32'd5, 32'd0};
        int acc [3];
        int idx, cyc, w;
        logic rdy;
        idx = 0; cyc = 0;
        alu_control = ADD; wr = 1'b1;
        addr1 = ops_a1[0]; addr2 = ops_a2[0]; addr3 = ops_a3[0]; use_imm = ops_ui[0]; imm = ops_im[0];
        in_valid = 1'b1;
        while (idx < 3 && cyc < 50) begin
            rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin
                acc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    addr1 = ops_a1[idx]; addr2 = ops_a2[idx]; addr3 = ops_a3[idx];
                    use_imm = ops_ui[idx]; imm = ops_im[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        w = 0;
        while (done !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", idx); end
        checks++; if (idx == 3 && ((acc[1] - acc[0]) !== 2 || (acc[2] - acc[1]) !== 2)) begin errors++; $display("FAIL b2b_spacing got %0d,%0d want 2,2", acc[1] - acc[0], acc[2] - acc[1]); end
        checks++; if (alu_result !== 32'd25) begin errors++; $display("FAIL b2b_result got %h want 19", alu_result); end
        dbg_addr = 3'd2; #1;
        checks++; if (dbg_data !== 32'd15) begin errors++; $display("FAIL b2b_r2 got %h want f", dbg_data); end
        dbg_addr = 3'd3; #1;
        checks++; if (dbg_data !== 32'd25) begin errors++; $display("FAIL b2b_r3 got %h want 19", dbg_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul;
        int l, n, pulses;
        alu_control = MUL; addr1 = 3'd1; addr2 = 3'd0; addr3 = 3'd7; wr = 1'b1; use_imm = 1'b1;
        imm = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL midrst_done_busy got %b want 00", {done, busy}); end
        checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL midrst_result got %h want 0", alu_result); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        dbg_addr = 3'd7; #1;
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", pulses); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL midrst_r7 got %h want 0", dbg_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        issue(ADD, 3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 32'd4, 0, l, n);
        checks++; if ({l, alu_result} !== {32'd1, 32'd4}) begin errors++; $display("FAIL post_rst_add got lat %0d result %h want 1/4", l, alu_result); end
    endtask

    initial begin
        test_reset;
        test_add_imm;
        test_add_sub;
        test_logic;
        test_mul;
        test_r0;
        test_back_to_back;
        test_reset_mid_mul;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
